// File: rtl/matrix_result_buffer_if.sv
// Product-capture and read-port bundle for matrix_result_buffer.
// Row-max select/result exist only when MATRIX_RESULT_ROWMAX_EN is defined.
interface matrix_result_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int AW     = 4
);
  localparam int CW  = $clog2(ROWS + 1);
  localparam int RSW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic              clear;
  logic              p_valid;
  logic [DATA_W-1:0] p_in;
  logic              row_done;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_done;
  logic              overflow;
  logic              row_err;
  logic [CW-1:0]     row_cnt;
`ifdef MATRIX_RESULT_ROWMAX_EN
  logic [RSW-1:0]    row_max_sel;
  logic [DATA_W-1:0] row_max;

  modport master (
    output clear, p_valid, p_in, row_done,
    output rd_en, rd_addr, row_max_sel,
    input  rd_data, rd_valid, frame_done,
    input  overflow, row_err, row_cnt, row_max
  );
  modport slave (
    input  clear, p_valid, p_in, row_done,
    input  rd_en, rd_addr, row_max_sel,
    output rd_data, rd_valid, frame_done,
    output overflow, row_err, row_cnt, row_max
  );
`else
  modport master (
    output clear, p_valid, p_in, row_done,
    output rd_en, rd_addr,
    input  rd_data, rd_valid, frame_done,
    input  overflow, row_err, row_cnt
  );
  modport slave (
    input  clear, p_valid, p_in, row_done,
    input  rd_en, rd_addr,
    output rd_data, rd_valid, frame_done,
    output overflow, row_err, row_cnt
  );
`endif
endinterface

// File: rtl/matrix_result_buffer.sv
// Result-matrix capture buffer behind the matrix multiplier.
// Optional per-row maxima: define MATRIX_RESULT_ROWMAX_EN.
module matrix_result_buffer #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int AW     = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  matrix_result_buffer_if.slave bus
);
  localparam int DEPTH = ROWS * COLS;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(ROWS + 1);
  localparam int RSW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     col_cnt_q, col_cnt_d;
  logic [CW-1:0]     row_cnt_q, row_cnt_d;
  logic              ovf_q, ovf_d;
  logic              rerr_q, rerr_d;
  logic              we;
  logic              frame_done;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              rd_in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      ovf_q     <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      ovf_q     <= ovf_d;
      rerr_q    <= rerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    ovf_d     = ovf_q;
    rerr_d    = rerr_q;
    we        = 1'b0;
    if (bus.clear) begin
      state_d   = IDLE;
      wr_ptr_d  = '0;
      col_cnt_d = '0;
      row_cnt_d = '0;
      ovf_d     = 1'b0;
      rerr_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, COLLECT: begin
          if (bus.p_valid) begin
            if (int'(wr_ptr_q) < DEPTH) begin
              we        = 1'b1;
              wr_ptr_d  = wr_ptr_q + PW'(1);
              col_cnt_d = col_cnt_q + PW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          // A product in the closing cycle counts toward the closing row
          if (bus.row_done) begin
            row_cnt_d = row_cnt_q + CW'(1);
            col_cnt_d = '0;
            wr_ptr_d  = PW'((int'(row_cnt_q) + 1) * COLS);
            if (int'(col_cnt_q) + int'(we) != COLS)
              rerr_d = 1'b1;
            if (int'(row_cnt_q) + 1 == ROWS)
              state_d = DONE;
            else
              state_d = COLLECT;
          end else if (bus.p_valid) begin
            state_d = COLLECT;
          end
        end
        DONE: begin
          if (bus.p_valid)
            ovf_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst_n && we)
      mem[wr_ptr_q[IW-1:0]] <= bus.p_in;
  end

  assign rd_in_range = int'(bus.rd_addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en)
        rd_data_q <= rd_in_range ? mem[bus.rd_addr[IW-1:0]] : '0;
    end
  end

`ifdef MATRIX_RESULT_ROWMAX_EN
  logic [DATA_W-1:0] max_q [ROWS];

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      for (int i = 0; i < ROWS; i++)
        max_q[i] <= '0;
    end else if (we && bus.p_in > max_q[row_cnt_q[RSW-1:0]]) begin
      max_q[row_cnt_q[RSW-1:0]] <= bus.p_in;
    end
  end

  assign bus.row_max = (int'(bus.row_max_sel) < ROWS)
                     ? max_q[bus.row_max_sel] : '0;
`endif

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.frame_done = frame_done;
  assign bus.overflow   = ovf_q;
  assign bus.row_err    = rerr_q;
  assign bus.row_cnt    = row_cnt_q;
endmodule

// File: tb/tb_matrix_result_buffer.sv
// Bench for matrix_result_buffer: directed vector table plus
// randomized traffic against a queue-based matrix model.
module tb_matrix_result_buffer;
  localparam int DW    = 16;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int AW    = 5;
  localparam int DEPTH = ROWS * COLS;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  matrix_result_buffer_if #(
    .DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .AW(AW)
  ) mif ();

  matrix_result_buffer #(
    .DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .AW(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: matrix as row count plus a queue for the open row
  int          m_rows;
  logic [15:0] m_cur [$];
  bit          m_done, m_ovf, m_rerr;
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_rd;
  bit          m_rdk, m_rv;
  logic [15:0] m_max [ROWS];

  typedef struct {
    bit          clr;
    bit          pv;
    logic [15:0] p;
    bit          rdone;
    bit          rd;
    logic [4:0]  ra;
    bit          fd;
    bit          ovf;
    bit          rerr;
    int          rcnt;
    bit          rv;
    bit          crd;
    logic [15:0] rdat;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic void model_clear();
    m_rows = 0;
    m_cur.delete();
    m_done = 0;
    m_ovf  = 0;
    m_rerr = 0;
    for (int i = 0; i < ROWS; i++) m_max[i] = '0;
  endfunction

  function automatic void model_step(bit clr, bit pv, logic [15:0] p,
                                     bit rdone, bit rd, int ra);
    int addr;
    m_rv = rd;
    if (rd) begin
      if (ra >= DEPTH) begin
        m_rd = '0; m_rdk = 1;
      end else begin
        m_rd = m_mem[ra]; m_rdk = m_known[ra];
      end
    end
    if (clr) begin
      model_clear();
      return;
    end
    if (m_done) begin
      if (pv) m_ovf = 1;
      return;
    end
    if (pv) begin
      addr = m_rows * COLS + m_cur.size();
      if (addr >= DEPTH) m_ovf = 1;
      else begin
        m_mem[addr]   = p;
        m_known[addr] = 1;
        m_cur.push_back(p);
        if (p > m_max[m_rows]) m_max[m_rows] = p;
      end
    end
    if (rdone) begin
      if (m_cur.size() != COLS) m_rerr = 1;
      m_cur.delete();
      m_rows++;
      if (m_rows == ROWS) m_done = 1;
    end
  endfunction

  task automatic apply(input bit clr, input bit pv, input logic [15:0] p,
                       input bit rdone, input bit rd, input logic [4:0] ra);
    mif.clear    = clr;
    mif.p_valid  = pv;
    mif.p_in     = p;
    mif.row_done = rdone;
    mif.rd_en    = rd;
    mif.rd_addr  = ra;
    @(posedge clk);
    #1;
    model_step(clr, pv, p, rdone, rd, int'(ra));
  endtask

  function automatic void add(bit clr, bit pv, logic [15:0] p, bit rdone,
                              bit rd, logic [4:0] ra, bit fd, bit ovf,
                              bit rerr, int rcnt, bit rv, bit crd,
                              logic [15:0] rdat);
    vec_t v;
    v.clr = clr; v.pv = pv; v.p = p; v.rdone = rdone;
    v.rd = rd; v.ra = ra; v.fd = fd; v.ovf = ovf; v.rerr = rerr;
    v.rcnt = rcnt; v.rv = rv; v.crd = crd; v.rdat = rdat;
    tbl.push_back(v);
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".frame_done"}, 32'(mif.frame_done), 32'(m_done));
    chk({tag, ".overflow"}, 32'(mif.overflow), 32'(m_ovf));
    chk({tag, ".row_err"}, 32'(mif.row_err), 32'(m_rerr));
    chk({tag, ".row_cnt"}, 32'(mif.row_cnt), 32'(m_rows));
    chk({tag, ".rd_valid"}, 32'(mif.rd_valid), 32'(m_rv));
    if (m_rdk) chk({tag, ".rd_data"}, 32'(mif.rd_data), 32'(m_rd));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    model_clear();
    m_rd = '0; m_rdk = 1; m_rv = 0;
    rst_n = 1'b0;
    mif.clear = 0; mif.p_valid = 0; mif.p_in = '0;
    mif.row_done = 0; mif.rd_en = 0; mif.rd_addr = '0;
`ifdef MATRIX_RESULT_ROWMAX_EN
    mif.row_max_sel = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst.frame_done", 32'(mif.frame_done), 32'd0);
    chk("rst.overflow", 32'(mif.overflow), 32'd0);
    chk("rst.row_err", 32'(mif.row_err), 32'd0);
    chk("rst.row_cnt", 32'(mif.row_cnt), 32'd0);
    chk("rst.rd_valid", 32'(mif.rd_valid), 32'd0);
    chk("rst.rd_data", 32'(mif.rd_data), 32'd0);

    // Full frame 1..16, row_done with each 4th product
    for (int k = 1; k <= 16; k++)
      add(0, 1, 16'(k), (k % 4) == 0, 0, 0,
          k == 16, 0, 0, k / 4, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5, 1, 0, 0, 4, 1, 1, 16'd6);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0, 1, 16'd6);
    add(0, 1, 16'hBEEF, 0, 0, 0, 1, 1, 0, 4, 0, 0, 0);
    add(0, 0, 0, 1, 1, 15, 1, 1, 0, 4, 1, 1, 16'd16);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 16, 0, 0, 0, 0, 1, 1, 16'd0);
    // Short row 0, then next product lands at row 1 base
    add(0, 1, 16'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'hB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 16'hD, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4, 0, 0, 1, 1, 1, 1, 16'hD);
    add(0, 0, 0, 0, 1, 3, 0, 0, 1, 1, 1, 1, 16'd4);
    // Product and row_done in the same cycle
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h24, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 1, 1, 16'h24);
    // Read-before-write on addr 2
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h32, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h1234, 0, 1, 2, 0, 0, 0, 0, 1, 1, 16'h23);
    add(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 1, 16'h1234);
    // row_done in IDLE, then clear racing a product
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 16'h31);
    add(0, 1, 16'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 16'h77);

    foreach (tbl[i]) begin
      apply(tbl[i].clr, tbl[i].pv, tbl[i].p, tbl[i].rdone,
            tbl[i].rd, tbl[i].ra);
      chk($sformatf("vec%0d.frame_done", i), 32'(mif.frame_done),
          32'(tbl[i].fd));
      chk($sformatf("vec%0d.overflow", i), 32'(mif.overflow),
          32'(tbl[i].ovf));
      chk($sformatf("vec%0d.row_err", i), 32'(mif.row_err),
          32'(tbl[i].rerr));
      chk($sformatf("vec%0d.row_cnt", i), 32'(mif.row_cnt),
          32'(tbl[i].rcnt));
      chk($sformatf("vec%0d.rd_valid", i), 32'(mif.rd_valid),
          32'(tbl[i].rv));
      if (tbl[i].crd)
        chk($sformatf("vec%0d.rd_data", i), 32'(mif.rd_data),
            32'(tbl[i].rdat));
    end

`ifdef MATRIX_RESULT_ROWMAX_EN
    apply(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) apply(0, 1, 16'd1, k == 3, 0, 0);
    apply(0, 1, 16'h0010, 0, 0, 0);
    apply(0, 1, 16'hFFFF, 0, 0, 0);
    apply(0, 1, 16'h0002, 0, 0, 0);
    apply(0, 1, 16'h8000, 1, 0, 0);
    mif.row_max_sel = 2'd1;
    #1;
    chk("rowmax.row1", 32'(mif.row_max), 32'hFFFF);
    mif.row_max_sel = 2'd0;
    #1;
    chk("rowmax.row0", 32'(mif.row_max), 32'h1);
    apply(1, 0, 0, 0, 0, 0);
    mif.row_max_sel = 2'd1;
    #1;
    chk("rowmax.clear", 32'(mif.row_max), 32'h0);
`endif

    apply(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      bit          clr, pv, rdone, rd;
      logic [15:0] p;
      logic [4:0]  ra;
      clr   = ($urandom_range(0, 39) == 0);
      pv    = ($urandom_range(0, 1) == 1);
      rdone = ($urandom_range(0, 5) == 0);
      rd    = ($urandom_range(0, 1) == 1);
      p     = 16'($urandom);
      ra    = 5'($urandom_range(0, 31));
`ifdef MATRIX_RESULT_ROWMAX_EN
      mif.row_max_sel = 2'($urandom_range(0, 3));
`endif
      apply(clr, pv, p, rdone, rd, ra);
      chk_model($sformatf("rnd%0d", c));
`ifdef MATRIX_RESULT_ROWMAX_EN
      chk($sformatf("rnd%0d.row_max", c), 32'(mif.row_max),
          32'(m_max[mif.row_max_sel]));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/matrix_result_buffer.md
Name: matrix_result_buffer

Overview:
- Downstream stage of the matrix multiplier in the matrix peripheral.
- Captures each 16-bit product P as the multiplier emits it and groups products into rows using the multiplier's row_done pulse.
- Stores one full result matrix in an internal buffer and raises frame_done when the matrix is complete.
- The host or bus side reads results by address with fixed 1-cycle latency.

Parameters:
- DATA_W, 16, product width (matches multiplier P).
- ROWS, 4, rows per result matrix.
- COLS, 4, products per row.
- AW, 4, read address width; must satisfy 2^AW >= ROWS*COLS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  one-cycle pulse: abort or finish the frame and return to IDLE.
- p_valid  in  1  p_in holds a valid product this cycle.
- p_in  in  DATA_W  product from multiplier.
- row_done  in  1  one-cycle pulse from multiplier marking end of current row.
- rd_en  in  1  read request.
- rd_addr  in  AW  read address, row-major: row*COLS+col.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data valid.
- frame_done  out  1  level; full matrix captured.
- overflow  out  1  sticky; product dropped.
- row_err  out  1  sticky; a row closed with count != COLS.
- row_cnt  out  clog2(ROWS+1)  rows completed.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk. On reset: state=IDLE; wr_ptr=0, col_cnt=0, row_cnt=0; rd_data=0, rd_valid=0, frame_done=0, overflow=0, row_err=0. Buffer contents are not reset.
- States: IDLE, COLLECT, DONE.
- IDLE -> COLLECT on first p_valid. That product is written at address 0 in the same cycle.
- COLLECT write: each p_valid writes mem[wr_ptr]=p_in, then wr_ptr++ and col_cnt++.
- COLLECT overflow: if p_valid arrives while wr_ptr==ROWS*COLS, the product is dropped and overflow=1.
- COLLECT row close: on row_done, row_cnt++ and col_cnt=0.
  - If the closing count != COLS, row_err=1. The closing count includes a simultaneous p_valid.
  - wr_ptr is realigned to the next row base ((row_cnt+1)*COLS); short rows leave stale cells.
  - A product arriving in the same cycle as row_done belongs to the row being closed.
- COLLECT -> DONE on the row_done that makes row_cnt==ROWS. frame_done=1 from the next cycle.
- row_done in IDLE: treated as an empty row. row_cnt++, row_err=1, state -> COLLECT.
- DONE: p_valid is dropped and sets overflow; row_done is ignored. Stays in DONE until clear.
- clear (any state): next cycle state=IDLE; wr_ptr, col_cnt, row_cnt cleared; frame_done, overflow, row_err cleared; buffer kept. If clear coincides with p_valid, clear wins and nothing is written.
- Reads: allowed in every state.
  - When rd_en=1 at cycle N: rd_data=mem[rd_addr] and rd_valid=1 at N+1. Otherwise rd_valid=0 and rd_data holds its value.
  - rd_addr >= ROWS*COLS returns 0.
  - Reading the address being written in the same cycle returns the old data (read-before-write).
- Arithmetic: no arithmetic on data; products are stored bit-exact.

Optional Feature:
- Macro: MATRIX_RESULT_ROWMAX_EN.
- When defined:
  - Adds per-row unsigned maximum registers, plus ports row_max_sel (in, clog2(ROWS)) and row_max (out, DATA_W, combinational from the register).
  - On each accepted product, max[row_cnt] = max(max[row_cnt], p_in).
  - Reset or clear zeroes all max registers.
  - Dropped products do not update the maxima.
- When undefined: no extra ports or registers; behaviour otherwise identical.

Test Plan:
- Reset, then 16 products 1..16 with row_done after every 4th -> frame_done=1 one cycle after the 4th row_done; row_cnt=4; reading addr 5 returns 6 with rd_valid one cycle after rd_en; overflow=0, row_err=0.
- Full frame captured, then p_valid with p_in=0xBEEF -> overflow=1; reading addr 15 still returns 16; clear -> overflow=0, frame_done=0, state IDLE.
- Row 0 gets 3 products (0xA,0xB,0xC) then row_done -> row_err=1; next product 0xD is written at addr 4; addr 3 holds its prior value.
- 4th product and row_done in the same cycle -> row_cnt=1, row_err=0, product stored at addr 3.
- Read addr 2 in the same cycle its product 0x1234 is written -> old value returned; re-read next cycle -> 0x1234. Reading addr 16 (AW=5 build) -> 0.
- With MATRIX_RESULT_ROWMAX_EN, row 1 products 0x0010,0xFFFF,0x0002,0x8000 -> row_max_sel=1 gives 0xFFFF; after clear gives 0.
